// File: rtl/gpio_bank_mm.sv
// gpio_bank_mm: memory-mapped GPIO bank on the shared LEGv8 tristate bus.
// CHANNELS channels of CH_WIDTH pins; each channel exposes OUT, DIR, IN and
// EDGE registers in a 32-byte slot starting at BASE_ADDR + c*32.
// Optional feature macro: GPIO_BANK_EDGE_IRQ_EN adds sticky rising-edge status
// (EDGE, write-1-to-clear) and the registered irq. Without it, EDGE reads 0,
// writes to EDGE are ignored and irq is tied low.
module gpio_bank_mm #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          CHANNELS    = 4,
  parameter int          CH_WIDTH    = 16,
  parameter int          DATA_WIDTH  = 64,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  inout  wire  [DATA_WIDTH-1:0]        data,
  input  logic [31:0]                  address,
  input  logic                         write_enable,
  input  logic                         read_enable,
  input  logic [1:0]                   size,
  inout  wire  [CHANNELS*CH_WIDTH-1:0] IO,
  output logic                         irq
);

  localparam int          NP     = CHANNELS * CH_WIDTH;
  localparam int          LW     = (DATA_WIDTH < 64) ? DATA_WIDTH : 64;
  localparam logic [31:0] WINDOW = 32'(CHANNELS * 32);

  // Bus semantics: there is no valid/ready pair on this bus. A load is a
  // purely combinational read: while read_enable is high and the address hits
  // the window, data is driven with the selected value, otherwise data is
  // high-Z. A store is accepted unconditionally at the rising clock edge when
  // write_enable is high, the address hits and the access is naturally
  // aligned. A read and a write in the same cycle see the pre-write value.

  logic [31:0]     offset;
  logic            hit;
  logic [2:0]      ch_sel;
  logic [1:0]      reg_sel;
  logic [2:0]      lane;
  logic [5:0]      shift;
  logic            aligned;
  logic            wr_go;
  logic [63:0]     size_mask;
  logic [63:0]     lane_mask;
  logic [63:0]     wr64;
  logic [63:0]     wr_shift;
  logic [63:0]     sel;
  logic [63:0]     merged;
  logic [63:0]     rd64;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [NP-1:0]   out_q;
  logic [NP-1:0]   dir_q;
  logic [NP-1:0]   in_val;
  logic [NP-1:0]   edge_rd;
  logic [NP-1:0]   sync_q [SYNC_STAGES];
  logic            unused_bits;

  // Window decode: channel in offset[7:5], register in [4:3], byte lane in [2:0].
  assign offset  = address - BASE_ADDR;
  assign hit     = (address >= BASE_ADDR) && (offset < WINDOW);
  assign ch_sel  = offset[7:5];
  assign reg_sel = offset[4:3];
  assign lane    = offset[2:0];
  assign shift   = {lane, 3'b000};

  // Access width mask and natural-alignment check for the requested size.
  always_comb begin
    size_mask = '1;
    aligned   = 1'b0;
    case (size)
      2'b00: begin
        size_mask = 64'h0000_0000_0000_00FF;
        aligned   = 1'b1;
      end
      2'b01: begin
        size_mask = 64'h0000_0000_0000_FFFF;
        aligned   = (lane[0] == 1'b0);
      end
      2'b10: begin
        size_mask = 64'h0000_0000_FFFF_FFFF;
        aligned   = (lane[1:0] == 2'b00);
      end
      default: begin
        size_mask = '1;
        aligned   = (lane == 3'b000);
      end
    endcase
  end

  assign lane_mask = size_mask << shift;
  assign wr_go     = write_enable && hit && aligned;

  // Bring the bus word to 64 bits; store data is right-justified on the bus.
  always_comb begin
    wr64         = '0;
    wr64[LW-1:0] = data[LW-1:0];
  end

  assign wr_shift = wr64 << shift;

  // Select the addressed register, zero-extended to the 64-bit register view.
  always_comb begin
    sel = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_sel == 3'(c)) begin
        case (reg_sel)
          2'd0:    sel[CH_WIDTH-1:0] = out_q[c*CH_WIDTH +: CH_WIDTH];
          2'd1:    sel[CH_WIDTH-1:0] = dir_q[c*CH_WIDTH +: CH_WIDTH];
          2'd2:    sel[CH_WIDTH-1:0] = in_val[c*CH_WIDTH +: CH_WIDTH];
          default: sel[CH_WIDTH-1:0] = edge_rd[c*CH_WIDTH +: CH_WIDTH];
        endcase
      end
    end
  end

  // Store merge: only the addressed byte lanes take new data.
  assign merged = (sel & ~lane_mask) | (wr_shift & lane_mask);

  // Load path: shift the first lane down, keep only the access width.
  always_comb begin
    rd64             = aligned ? ((sel >> shift) & size_mask) : 64'd0;
    rd_data          = '0;
    rd_data[LW-1:0]  = rd64[LW-1:0];
  end

  assign data = (read_enable && hit) ? rd_data : {DATA_WIDTH{1'bz}};

  // Pin drivers: each pin is driven from OUT only while its DIR bit is set.
  for (genvar i = 0; i < NP; i++) begin : g_pin
    assign IO[i] = dir_q[i] ? out_q[i] : 1'bz;
  end

  // OUT and DIR registers; reset wins over a coincident store.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_q <= '0;
      dir_q <= '0;
    end else if (wr_go) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (ch_sel == 3'(c)) begin
          if (reg_sel == 2'd0) out_q[c*CH_WIDTH +: CH_WIDTH] <= merged[CH_WIDTH-1:0];
          if (reg_sel == 2'd1) dir_q[c*CH_WIDTH +: CH_WIDTH] <= merged[CH_WIDTH-1:0];
        end
      end
    end
  end

  // Input synchroniser chain; output pins are sampled too, giving read-back.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= IO;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign in_val = sync_q[SYNC_STAGES-1];

`ifdef GPIO_BANK_EDGE_IRQ_EN
  logic [NP-1:0] hist_q;
  logic [NP-1:0] edge_q;
  logic [NP-1:0] rise;
  logic [NP-1:0] clr;
  logic [63:0]   clr64;

  assign clr64 = wr_shift & lane_mask;
  assign rise  = in_val & ~hist_q;

  // Write-1-to-clear mask for the addressed EDGE register.
  always_comb begin
    clr = '0;
    if (wr_go && (reg_sel == 2'd3)) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (ch_sel == 3'(c)) clr[c*CH_WIDTH +: CH_WIDTH] = clr64[CH_WIDTH-1:0];
      end
    end
  end

  // Edge history, sticky status (a new edge beats a same-cycle clear) and irq.
  always_ff @(posedge clock) begin
    if (reset) begin
      hist_q <= '0;
      edge_q <= '0;
      irq    <= 1'b0;
    end else begin
      hist_q <= in_val;
      edge_q <= (edge_q & ~clr) | rise;
      irq    <= |edge_q;
    end
  end

  assign edge_rd     = edge_q;
  assign unused_bits = ^{merged, clr64};
`else
  assign edge_rd     = '0;
  assign irq         = 1'b0;
  assign unused_bits = ^merged;
`endif

endmodule
